// File: rtl/noc_pkg.sv
// -----------------------------------------------------------------------------
// noc_pkg
// Shared types and default widths for the tile's network-injection logic.
//   inject_state_e : IDLE (nothing presented) / BUSY (packet held on i_*)
//   noc_pkt_t      : packet shape {vc, x, y, data} at the default widths; blocks
//                    built with other widths declare the same field order locally
// -----------------------------------------------------------------------------
package noc_pkg;

    localparam int N_REQ_DEF = 4;
    localparam int VC_W_DEF  = 3;
    localparam int X_W_DEF   = 2;
    localparam int Y_W_DEF   = 2;
    localparam int D_W_DEF   = 32;
    localparam int RATE_DEF  = 20;
    localparam int SIGMA_DEF = 3;
    localparam int CNT_W_DEF = 16;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } inject_state_e;

    typedef struct packed {
        logic [VC_W_DEF-1:0] vc;
        logic [X_W_DEF-1:0]  x;
        logic [Y_W_DEF-1:0]  y;
        logic [D_W_DEF-1:0]  data;
    } noc_pkt_t;

endpackage

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin pick: grants the first set bit of elig at or above
// ptr, wrapping modulo N_REQ.
//   elig : request vector
//   ptr  : highest-priority index this cycle
//   gnt  : one-hot grant, all-zero when elig is all-zero
// -----------------------------------------------------------------------------
module rr_arbiter #(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0]         elig,
    input  logic [$clog2(N_REQ)-1:0] ptr,
    output logic [N_REQ-1:0]         gnt
);

    localparam int PTR_W = $clog2(N_REQ);

    logic found;

    // Two fixed-order passes (indices >= ptr, then indices < ptr) give the
    // circular search without a variable index.
    // NOTE: every output of a combinational block gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        gnt   = '0;
        found = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (!found && elig[i] && (PTR_W'(i) >= ptr)) begin
                gnt[i] = 1'b1;
                found  = 1'b1;
            end
        end
        for (int i = 0; i < N_REQ; i++) begin
            if (!found && elig[i] && (PTR_W'(i) < ptr)) begin
                gnt[i] = 1'b1;
                found  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/inject_arbiter.sv
// -----------------------------------------------------------------------------
// inject_arbiter
// Shares one router injection port among N_REQ local packet sources. A
// round-robin pick registers the winner's packet onto i_*, where it is held
// until i_ack. A new packet may load in the ack cycle, so streams have no
// bubble.
//   req_v / req_gnt           : per-requester valid and one-hot grant (comb.)
//   req_vc/x/y/data           : flattened packet fields, slice i = requester i
//   i_v/i_vc/i_x/i_y/i_data   : held packet toward the router
//   i_ack                     : router accepted the held packet
//   i_b                       : one-hot of i_vc while i_v, else 0
//   sent_cnt                  : acknowledged packets since reset (wraps)
// Build option: define INJECT_ARB_SHAPING_EN to add a per-requester token
// bucket (depth SIGMA, +1 token every RATE cycles) gating eligibility.
// -----------------------------------------------------------------------------
module inject_arbiter
    import noc_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF,
    parameter int VC_W  = VC_W_DEF,
    parameter int X_W   = X_W_DEF,
    parameter int Y_W   = Y_W_DEF,
    parameter int D_W   = D_W_DEF,
    parameter int RATE  = RATE_DEF,
    parameter int SIGMA = SIGMA_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N_REQ-1:0]      req_v,
    output logic [N_REQ-1:0]      req_gnt,
    input  logic [N_REQ*VC_W-1:0] req_vc,
    input  logic [N_REQ*X_W-1:0]  req_x,
    input  logic [N_REQ*Y_W-1:0]  req_y,
    input  logic [N_REQ*D_W-1:0]  req_data,
    output logic                  i_v,
    input  logic                  i_ack,
    output logic [VC_W-1:0]       i_vc,
    output logic [X_W-1:0]        i_x,
    output logic [Y_W-1:0]        i_y,
    output logic [D_W-1:0]        i_data,
    output logic [VC_W-1:0]       i_b,
    output logic [CNT_W-1:0]      sent_cnt
);

    localparam int PTR_W = $clog2(N_REQ);

    if (N_REQ < 2 || RATE < 1 || SIGMA < 1) begin : g_bad_param
        $error("inject_arbiter: N_REQ must be >= 2, RATE and SIGMA >= 1");
    end

    typedef struct packed {
        logic [VC_W-1:0] vc;
        logic [X_W-1:0]  x;
        logic [Y_W-1:0]  y;
        logic [D_W-1:0]  data;
    } pkt_t;

    inject_state_e    state_q, state_d;
    logic [PTR_W-1:0] ptr_q, ptr_d;
    pkt_t             pkt_q, pkt_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             can_load;
    logic [N_REQ-1:0] elig;
    logic [N_REQ-1:0] arb_gnt;

    // i_ack only matters while a packet is held.
    assign can_load = (state_q == IDLE) || i_ack;

`ifdef INJECT_ARB_SHAPING_EN
    localparam int TOK_W  = $clog2(SIGMA + 1);
    localparam int RATE_W = (RATE > 1) ? $clog2(RATE) : 1;

    logic [TOK_W-1:0]  tok_q [N_REQ];
    logic [TOK_W-1:0]  tok_d [N_REQ];
    logic [RATE_W-1:0] rate_q, rate_d;
    logic              refill;

    assign refill = (rate_q == RATE_W'(RATE - 1));
    assign rate_d = refill ? '0 : rate_q + 1'b1;

    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            elig[i] = req_v[i] && (tok_q[i] != '0);
        end
    end

    // A refill landing in a grant cycle cancels the spend, so a full bucket
    // stays full rather than dipping to SIGMA-1.
    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            tok_d[i] = tok_q[i];
            if (req_gnt[i] && !refill) begin
                tok_d[i] = tok_q[i] - 1'b1;
            end else if (refill && !req_gnt[i] && (tok_q[i] != TOK_W'(SIGMA))) begin
                tok_d[i] = tok_q[i] + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rate_q <= '0;
            for (int i = 0; i < N_REQ; i++) begin
                tok_q[i] <= TOK_W'(SIGMA);
            end
        end else begin
            rate_q <= rate_d;
            for (int i = 0; i < N_REQ; i++) begin
                tok_q[i] <= tok_d[i];
            end
        end
    end
`else
    assign elig = req_v;
`endif

    rr_arbiter #(
        .N_REQ (N_REQ)
    ) u_rr_arbiter (
        .elig (elig),
        .ptr  (ptr_q),
        .gnt  (arb_gnt)
    );

    assign req_gnt = can_load ? arb_gnt : '0;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        pkt_d   = pkt_q;
        cnt_d   = cnt_q;

        if ((state_q == BUSY) && i_ack) begin
            cnt_d = cnt_q + 1'b1;
        end

        if (can_load) begin
            state_d = IDLE;
            for (int i = 0; i < N_REQ; i++) begin
                if (req_gnt[i]) begin
                    state_d    = BUSY;
                    pkt_d.vc   = req_vc[i*VC_W +: VC_W];
                    pkt_d.x    = req_x[i*X_W +: X_W];
                    pkt_d.y    = req_y[i*Y_W +: Y_W];
                    pkt_d.data = req_data[i*D_W +: D_W];
                    ptr_d      = (i == N_REQ - 1) ? '0 : PTR_W'(i + 1);
                end
            end
        end
    end

    // NOTE: state registers use non-blocking assignment so every flop samples
    // the pre-edge value of every other flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            pkt_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            pkt_q   <= pkt_d;
            cnt_q   <= cnt_d;
        end
    end

    assign i_v      = (state_q == BUSY);
    assign i_vc     = pkt_q.vc;
    assign i_x      = pkt_q.x;
    assign i_y      = pkt_q.y;
    assign i_data   = pkt_q.data;
    assign sent_cnt = cnt_q;

    always_comb begin
        for (int k = 0; k < VC_W; k++) begin
            i_b[k] = i_v && (pkt_q.vc == VC_W'(k));
        end
    end

endmodule

// File: tb/tb_inject_arbiter.sv
// -----------------------------------------------------------------------------
// tb_inject_arbiter
// Scoreboarded bench for inject_arbiter: expected grant indices are queued as
// stimulus is applied; a negedge monitor matches them against req_gnt and
// queues the expected packet, which is compared when the router acks it.
// -----------------------------------------------------------------------------
module tb_inject_arbiter;

    localparam int N  = 4;
    localparam int VW = 3;
    localparam int XW = 2;
    localparam int YW = 2;
    localparam int DW = 32;
    localparam int CW = 16;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N-1:0]    req_v = '0;
    logic [N-1:0]    req_gnt;
    logic [N*VW-1:0] req_vc = '0;
    logic [N*XW-1:0] req_x = '0;
    logic [N*YW-1:0] req_y = '0;
    logic [N*DW-1:0] req_data = '0;
    logic            i_v;
    logic            i_ack = 1'b0;
    logic [VW-1:0]   i_vc;
    logic [XW-1:0]   i_x;
    logic [YW-1:0]   i_y;
    logic [DW-1:0]   i_data;
    logic [VW-1:0]   i_b;
    logic [CW-1:0]   sent_cnt;

    int          n_cmp = 0;
    int          n_err = 0;
    int          exp_idx_q[$];
    logic [63:0] exp_pkt_q[$];
    logic [31:0] data_base = 32'h1000_0000;

    always #5 clk = ~clk;

    inject_arbiter u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req_v    (req_v),
        .req_gnt  (req_gnt),
        .req_vc   (req_vc),
        .req_x    (req_x),
        .req_y    (req_y),
        .req_data (req_data),
        .i_v      (i_v),
        .i_ack    (i_ack),
        .i_vc     (i_vc),
        .i_x      (i_x),
        .i_y      (i_y),
        .i_data   (i_data),
        .i_b      (i_b),
        .sent_cnt (sent_cnt)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Requester i carries vc=i%3, x=i, y=3-i, data=data_base+i.
    task automatic load_fields();
        for (int i = 0; i < N; i++) begin
            req_vc[i*VW +: VW]   = VW'(i % 3);
            req_x[i*XW +: XW]    = XW'(i);
            req_y[i*YW +: YW]    = YW'(3 - i);
            req_data[i*DW +: DW] = data_base + 32'(i);
        end
    endtask

    function automatic logic [63:0] exp_pkt(input int i, input logic [31:0] base);
        logic [VW-1:0] vc;
        logic [VW-1:0] b;
        vc = VW'(i % 3);
        b  = VW'(1) << (i % 3);
        return {22'd0, b, vc, XW'(i), YW'(3 - i), base + 32'(i)};
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (i_v && i_ack) begin
                if (exp_pkt_q.size() == 0) begin
                    check("accept_unexpected", 64'(i_data), 64'hDEAD);
                end else begin
                    check("packet", {22'd0, i_b, i_vc, i_x, i_y, i_data}, exp_pkt_q.pop_front());
                end
            end
            if (req_gnt != '0) begin
                if (exp_idx_q.size() == 0) begin
                    check("grant_unexpected", 64'(req_gnt), 64'd0);
                end else begin
                    int idx;
                    idx = exp_idx_q.pop_front();
                    check("grant", 64'(req_gnt), 64'd1 << idx);
                    exp_pkt_q.push_back(exp_pkt(idx, data_base));
                end
            end else if (exp_idx_q.size() != 0) begin
                check("grant_missing", 64'(req_gnt), 64'd1 << exp_idx_q.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        load_fields();
        next_cycle();
        rst_n = 1'b1;

        // Reset state.
        @(negedge clk);
        check("rst_i_v", 64'(i_v), 64'd0);
        check("rst_i_b", 64'(i_b), 64'd0);
        check("rst_sent_cnt", 64'(sent_cnt), 64'd0);
        check("rst_req_gnt", 64'(req_gnt), 64'd0);
        check("rst_i_data", 64'(i_data), 64'd0);
        next_cycle();

        // Single requester, held 5 cycles without ack.
        data_base = 32'hA000_0000;
        load_fields();
        req_v = 4'b0010;
        exp_idx_q.push_back(1);
        @(negedge clk);
        next_cycle();
        req_v = '0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("hold_i_v", 64'(i_v), 64'd1);
            check("hold_data", 64'(i_data), 64'(data_base + 32'd1));
            next_cycle();
        end
        i_ack = 1'b1;
        @(negedge clk);
        next_cycle();
        i_ack = 1'b0;
        @(negedge clk);
        check("single_i_v_after_ack", 64'(i_v), 64'd0);
        check("single_sent_cnt", 64'(sent_cnt), 64'd1);
        next_cycle();

        // Ack while idle is ignored.
        i_ack = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            check("idle_ack_i_v", 64'(i_v), 64'd0);
            check("idle_ack_sent_cnt", 64'(sent_cnt), 64'd1);
            next_cycle();
        end

        // Skip and pointer: ptr=2, req_v=0011 -> 0 then 1, ptr ends at 2.
        data_base = 32'hB000_0000;
        load_fields();
        req_v = 4'b0011;
        exp_idx_q.push_back(0);
        @(negedge clk);
        next_cycle();
        exp_idx_q.push_back(1);
        @(negedge clk);
        check("skip_no_bubble", 64'(i_v), 64'd1);
        next_cycle();
        req_v = '0;
        @(negedge clk);
        next_cycle();
        req_v = 4'b0101;
        i_ack = 1'b0;
        exp_idx_q.push_back(2);
        @(negedge clk);
        next_cycle();
        req_v = '0;
        i_ack = 1'b1;
        @(negedge clk);
        next_cycle();
        i_ack = 1'b0;
        @(negedge clk);
        check("skip_sent_cnt", 64'(sent_cnt), 64'd4);
        check("skip_i_v", 64'(i_v), 64'd0);
        next_cycle();

        // Asynchronous reset while a packet is held.
        req_v = 4'b1000;
        exp_idx_q.push_back(3);
        @(negedge clk);
        next_cycle();
        req_v = '0;
        @(negedge clk);
        check("pre_rst_i_v", 64'(i_v), 64'd1);
        check("pre_rst_i_b", 64'(i_b), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_i_v", 64'(i_v), 64'd0);
        check("async_rst_i_b", 64'(i_b), 64'd0);
        check("async_rst_sent_cnt", 64'(sent_cnt), 64'd0);
        exp_idx_q.delete();
        exp_pkt_q.delete();
        next_cycle();
        rst_n = 1'b1;

        // Fairness with continuous ack; pointer restarts at 0 after reset.
        data_base = 32'hC000_0000;
        load_fields();
        req_v = 4'b1111;
        i_ack = 1'b1;
        for (int c = 0; c < 9; c++) begin
            exp_idx_q.push_back(c % 4);
            @(negedge clk);
            if (c > 0) check("fair_no_bubble", 64'(i_v), 64'd1);
            next_cycle();
        end
        req_v = '0;
        @(negedge clk);
        check("fair_sent_cnt_8", 64'(sent_cnt), 64'd8);
        next_cycle();
        i_ack = 1'b0;
        @(negedge clk);
        check("fair_sent_cnt_9", 64'(sent_cnt), 64'd9);
        check("fair_drained_i_v", 64'(i_v), 64'd0);
        next_cycle();

`ifdef INJECT_ARB_SHAPING_EN
        // Token-bucket shaping on requester 0 with continuous ack.
        begin
            int tok;
            int rc;
            int model_grants;
            bit g;
            bit refill;
            rst_n = 1'b0;
            exp_idx_q.delete();
            exp_pkt_q.delete();
            next_cycle();
            rst_n = 1'b1;
            data_base = 32'hD000_0000;
            load_fields();
            tok = 3;
            rc = 0;
            model_grants = 0;
            for (int c = 0; c < 70; c++) begin
                req_v = 4'b0001;
                i_ack = 1'b1;
                g = (tok > 0);
                if (g) begin
                    exp_idx_q.push_back(0);
                    model_grants++;
                end
                @(negedge clk);
                next_cycle();
                refill = (rc == 19);
                if (g && !refill) tok--;
                else if (refill && !g && tok < 3) tok++;
                rc = refill ? 0 : rc + 1;
            end
            check("shape_grant_total", 64'(model_grants), 64'd6);
            req_v = '0;
            @(negedge clk);
            next_cycle();
            i_ack = 1'b0;
        end
`endif

        check("exp_idx_q_empty", 64'(exp_idx_q.size()), 64'd0);
        check("exp_pkt_q_empty", 64'(exp_pkt_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/inject_arbiter.md
# inject_arbiter

Shares one router injection port among N_REQ local packet sources. Each cycle, a round-robin arbiter picks one valid requester and registers its packet onto the injection interface. The packet is held there until the router acknowledges it. An optional per-requester token-bucket shaper limits each source to a burst of SIGMA packets, refilled by one token every RATE cycles. The block sits between the traffic clients of a tile and its router's i_* port.

## Interface
- N_REQ, 4, number of requesters (≥2)
- VC_W, 3, virtual-channel field width
- X_W, 2, destination X width
- Y_W, 2, destination Y width
- D_W, 32, payload width
- RATE, 20, cycles per token refill (shaping only, ≥1)
- SIGMA, 3, bucket depth in tokens (shaping only, ≥1)
- CNT_W, 16, sent-packet counter width
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_v  in  N_REQ  requester i has a packet
- req_gnt  out  N_REQ  one-hot; transfer from i when req_v[i] & req_gnt[i]
- req_vc  in  N_REQ*VC_W  flattened, slice i = requester i
- req_x  in  N_REQ*X_W  flattened destination X
- req_y  in  N_REQ*Y_W  flattened destination Y
- req_data  in  N_REQ*D_W  flattened payload
- i_v  out  1  packet presented to router
- i_ack  in  1  router accepted the held packet
- i_vc / i_x / i_y / i_data  out  VC_W / X_W / Y_W / D_W  held packet fields
- i_b  out  VC_W  one-hot of held i_vc while i_v=1, else 0
- sent_cnt  out  CNT_W  packets acknowledged since reset, wraps

## Operation
- Two states.
  - IDLE: i_v=0.
  - BUSY: i_v=1; fields stable until i_ack.
- can_load = IDLE | (BUSY & i_ack).
- elig[i] = req_v[i], ANDed with tok[i]≠0 when shaping is compiled in.
- When can_load and any elig:
  - Grant the first eligible index at or after ptr, searching upward modulo N_REQ.
  - Assert req_gnt for that index combinationally in the same cycle.
  - Capture its fields.
  - Next state is BUSY.
  - ptr ← winner+1 mod N_REQ.
- When can_load and no elig: next state is IDLE; ptr is unchanged.
- req_gnt is all-zero whenever can_load=0.
- i_ack while IDLE is ignored.
- sent_cnt increments on BUSY & i_ack and wraps to 0 at 2^CNT_W.
- Reset values:
  - state IDLE, ptr 0, req_gnt 0, i_v 0.
  - i_vc, i_x, i_y, i_data, i_b all 0; sent_cnt 0.
  - tok[i]=SIGMA; rate counter 0.
- Reset asserted mid-packet drops the held packet with no ack. Requesters must treat an ungranted req_v as still pending.

## Timing
- Latency is 1 cycle: a grant at edge t gives i_v=1 with the new fields after edge t.
- Back-to-back: an i_ack cycle with a waiting eligible requester reloads in that same cycle, so i_v stays 1 with no bubble.
- Fully combinational paths: req_v → req_gnt, i_ack → req_gnt.
- Shaping arithmetic:
  - rate_cnt counts 0..RATE-1; refill pulse when rate_cnt=RATE-1.
  - tok width is $clog2(SIGMA+1).
  - Refill adds 1, saturating at SIGMA.
  - Grant to i subtracts 1.
  - Refill and grant in the same cycle: the net change is 0 regardless of the starting level, so a full bucket stays at SIGMA.

## Configuration
- INJECT_ARB_SHAPING_EN defined:
  - Per-requester buckets and the rate counter are built.
  - Eligibility requires tok[i]≠0.
- Undefined:
  - No buckets, no rate counter; elig = req_v.
  - RATE and SIGMA are unused.
  - All other behaviour is identical.

## Structure
- Shared package noc_pkg holds:
  - inject_state_e {IDLE, BUSY}.
  - A packet struct {vc, x, y, data} parameterised through widths, mirroring the client's i_* fields.
  - Default width constants.
- Sub-module rr_arbiter (N_REQ; inputs elig, ptr; output one-hot gnt; combinational), so other schedulers in the tile can reuse it.
- Token buckets stay inline under the macro.

## Test plan
- Single requester: req_v=0010, IDLE → req_gnt=0010 same cycle; i_v=1 next cycle with requester 1's fields; stable for 5 cycles without ack; i_ack → sent_cnt=1, i_v=0.
- Fairness: req_v=1111 held, i_ack=1 every cycle → grant order 0,1,2,3,0; no bubbles on i_v; after 8 acks sent_cnt=8.
- Skip and pointer: ptr=2, req_v=0011 → grant 0 then 1; ptr ends at 2.
- Shaping on (RATE=20, SIGMA=3): req_v=0001 held, ack every cycle → exactly 3 grants, then none until the refill at cycle 20, then 1 grant per 20 cycles. A refill in a grant cycle at tok=3 keeps tok=3.
- Reset mid-packet: BUSY, rst_n low for 1 cycle asynchronously → i_v=0, i_b=0, sent_cnt=0, tok=SIGMA immediately; ptr=0 after release.
- i_ack while IDLE → no state change, sent_cnt unchanged.
